// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
// Shares one single-port memory between the instruction-fetch requester and
// the data (load/store) requester of the multicycle CPU. The winning request
// is registered, the memory strobe is held until the memory acknowledges (or
// a timeout expires), and the result is returned with a one-cycle done pulse.
//
// Build option: define ARB_ROUND_ROBIN_EN to alternate the winner on
// simultaneous requests. Without it, data requests always beat fetches.
//
// state | meaning
// IDLE  | no access in flight, requests are sampled here
// BUSY  | memory strobe high, waiting for mem_ready or timeout
// DONE  | owner's done pulse (err if aborted), strobe low, back to IDLE

module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              Reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_done,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_done,
    output logic              err,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        BUSY = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic OWN_IF = 1'b0;
    localparam logic OWN_DM = 1'b1;

    // last BUSY cycle index before the access is abandoned
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic       owner;
    logic [7:0] cnt;
    logic       pick_dm;

`ifdef ARB_ROUND_ROBIN_EN
    logic last;

    // on a tie, the requester that was not served last time wins
    always_comb begin
        pick_dm = 1'b0;
        if (dm_req && !if_req) begin
            pick_dm = 1'b1;
        end else if (dm_req && if_req) begin
            pick_dm = (last == OWN_IF);
        end
    end

    // remember who was served, updated as each access completes
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            last <= OWN_IF;
        end else if (state == DONE) begin
            last <= owner;
        end
    end
`else
    // fixed priority: data accesses always beat instruction fetches
    always_comb begin
        pick_dm = dm_req;
    end
`endif

    // access sequencer: grant, strobe/wait/timeout, done pulse
    always_ff @(posedge clk or negedge Reset) begin
        if (!Reset) begin
            state     <= IDLE;
            owner     <= OWN_IF;
            cnt       <= '0;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            if_rdata  <= '0;
            dm_rdata  <= '0;
            if_done   <= 1'b0;
            dm_done   <= 1'b0;
            err       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    err     <= 1'b0;
                    if (if_req || dm_req) begin
                        cnt    <= '0;
                        mem_en <= 1'b1;
                        if (pick_dm) begin
                            owner     <= OWN_DM;
                            mem_addr  <= dm_addr;
                            mem_wdata <= dm_wdata;
                            mem_we    <= dm_we;
                        end else begin
                            // fetches never write
                            owner     <= OWN_IF;
                            mem_addr  <= if_addr;
                            mem_wdata <= '0;
                            mem_we    <= 1'b0;
                        end
                        state <= BUSY;
                    end
                end

                BUSY: begin
                    if (mem_ready) begin
                        if (owner == OWN_DM) begin
                            dm_rdata <= mem_rdata;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= mem_rdata;
                            if_done  <= 1'b1;
                        end
                        err    <= 1'b0;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        // memory never answered: return zero data flagged as error
                        if (owner == OWN_DM) begin
                            dm_rdata <= '0;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= '0;
                            if_done  <= 1'b1;
                        end
                        err    <= 1'b1;
                        mem_en <= 1'b0;
                        mem_we <= 1'b0;
                        state  <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                DONE: begin
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    err     <= 1'b0;
                    state   <= IDLE;
                end

                default: begin
                    // unreachable encoding: park safely
                    if_done <= 1'b0;
                    dm_done <= 1'b0;
                    err     <= 1'b0;
                    mem_en  <= 1'b0;
                    mem_we  <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
// Drives both requesters and a memory responder with random latency. The
// expected timeline of each access is computed up front from the memory
// latency k: the strobe lasts min(k+1, TIMEOUT) cycles, the done pulse
// follows, then one idle cycle.

module tb_mem_port_arbiter;

    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 15;

    logic              clk = 1'b0;
    logic              Reset;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_done;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_done;
    logic              err;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ready;

    mem_port_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk      (clk),
        .Reset    (Reset),
        .if_req   (if_req),
        .if_addr  (if_addr),
        .if_rdata (if_rdata),
        .if_done  (if_done),
        .dm_req   (dm_req),
        .dm_we    (dm_we),
        .dm_addr  (dm_addr),
        .dm_wdata (dm_wdata),
        .dm_rdata (dm_rdata),
        .dm_done  (dm_done),
        .err      (err),
        .mem_en   (mem_en),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .mem_ready(mem_ready)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // reference state: who was served last, and each port's held read data
    bit          last_dm;
    logic [31:0] m_if_rdata;
    logic [31:0] m_dm_rdata;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // arbitration rule applied to the requests present when the grant happens
    function automatic bit model_pick_dm(input bit ifr, input bit dmr, input bit last_was_dm);
        if (!dmr) return 1'b0;
        if (!ifr) return 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        return !last_was_dm;
`else
        return 1'b1;
`endif
    endfunction

    task automatic raise_if();
        if_req  = 1'b1;
        if_addr = $urandom & 32'hFFFF_FFFC;
    endtask

    task automatic raise_dm();
        dm_req   = 1'b1;
        dm_we    = 1'($urandom_range(0, 1));
        dm_addr  = $urandom & 32'hFFFF_FFFC;
        dm_wdata = $urandom;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_en"},   32'(mem_en),  32'd0);
        check({tag, "_we"},   32'(mem_we),  32'd0);
        check({tag, "_ifd"},  32'(if_done), 32'd0);
        check({tag, "_dmd"},  32'(dm_done), 32'd0);
        check({tag, "_err"},  32'(err),     32'd0);
    endtask

    // One complete access. Called in an IDLE cycle with at least one request
    // driven; returns in the idle cycle that follows the done pulse.
    task automatic run_access(input int k, input logic [31:0] rd);
        bit          win_dm;
        bit          tmo;
        int          n;
        logic [31:0] e_addr;
        logic [31:0] e_wdata;
        bit          e_we;

        if (!if_req && !dm_req) begin
            check("no_request_pending", 32'd0, 32'd1);
            return;
        end
        win_dm  = model_pick_dm(if_req, dm_req, last_dm);
        e_addr  = win_dm ? dm_addr : if_addr;
        e_wdata = dm_wdata;
        e_we    = win_dm ? dm_we : 1'b0;
        tmo     = (k >= TIMEOUT);
        n       = tmo ? TIMEOUT : k + 1;
        // stray acknowledge while idle must be ignored
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;

        for (int j = 0; j < n; j++) begin
            tick();
            check("busy_en",   32'(mem_en),  32'd1);
            check("busy_addr", mem_addr,     e_addr);
            check("busy_we",   32'(mem_we),  32'(e_we));
            if (e_we) check("busy_wdata", mem_wdata, e_wdata);
            check("busy_ifd",  32'(if_done), 32'd0);
            check("busy_dmd",  32'(dm_done), 32'd0);
            mem_ready = (j == k);
            mem_rdata = (j == k) ? rd : $urandom;
            // the winner's inputs may wander once the grant is registered
            if (win_dm) begin
                dm_addr  = $urandom;
                dm_wdata = $urandom;
                dm_we    = 1'($urandom_range(0, 1));
            end else begin
                if_addr = $urandom;
            end
        end

        tick();
        if (win_dm) m_dm_rdata = tmo ? 32'd0 : rd;
        else        m_if_rdata = tmo ? 32'd0 : rd;
        check("done_ifd",   32'(if_done), 32'(!win_dm));
        check("done_dmd",   32'(dm_done), 32'(win_dm));
        check("done_err",   32'(err),     32'(tmo));
        check("done_ifrd",  if_rdata,     m_if_rdata);
        check("done_dmrd",  dm_rdata,     m_dm_rdata);
        check("done_en",    32'(mem_en),  32'd0);
        check("done_we",    32'(mem_we),  32'd0);
        mem_ready = 1'($urandom_range(0, 1));
        mem_rdata = $urandom;
        if (win_dm) dm_req = 1'b0;
        else        if_req = 1'b0;
        last_dm = win_dm;

        tick();
        check_quiet("post");
        check("post_ifrd", if_rdata, m_if_rdata);
        check("post_dmrd", dm_rdata, m_dm_rdata);
        mem_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_en"},    32'(mem_en),  32'd0);
        check({tag, "_we"},    32'(mem_we),  32'd0);
        check({tag, "_addr"},  mem_addr,     32'd0);
        check({tag, "_wdata"}, mem_wdata,    32'd0);
        check({tag, "_ifrd"},  if_rdata,     32'd0);
        check({tag, "_dmrd"},  dm_rdata,     32'd0);
        check({tag, "_ifd"},   32'(if_done), 32'd0);
        check({tag, "_dmd"},   32'(dm_done), 32'd0);
        check({tag, "_err"},   32'(err),     32'd0);
    endtask

    initial begin
        int k;
        int sel;
        int idle_n;

        Reset     = 1'b0;
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_addr   = '0;
        dm_wdata  = '0;
        mem_rdata = '0;
        mem_ready = 1'b0;
        last_dm    = 1'b0;
        m_if_rdata = '0;
        m_dm_rdata = '0;

        #1;
        check_all_zero("rst");
        repeat (2) @(negedge clk);
        Reset = 1'b1;

        // fetch, memory answers in the first strobe cycle
        if_req  = 1'b1;
        if_addr = 32'h0000_0004;
        run_access(0, 32'h2002_0001);

        // store with three wait cycles
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 32'h0000_0010;
        dm_wdata = 32'hDEAD_BEEF;
        run_access(3, $urandom);

        // two simultaneous pairs
        for (int p = 0; p < 2; p++) begin
            raise_if();
            raise_dm();
            run_access(1, $urandom);
            run_access(0, $urandom);
        end

        // timeout boundary: answer on the last allowed cycle, then never
        raise_if();
        run_access(TIMEOUT - 1, $urandom);
        raise_dm();
        run_access(TIMEOUT + 3, $urandom);

        // reset in the middle of an access
        raise_dm();
        tick();
        tick();
        check("rstmid_en", 32'(mem_en), 32'd1);
        #1;
        Reset = 1'b0;
        #1;
        check_all_zero("rstmid");
        dm_req = 1'b0;
        raise_if();
        last_dm    = 1'b0;
        m_if_rdata = '0;
        m_dm_rdata = '0;
        tick();
        check_all_zero("rsthold");
        @(negedge clk);
        Reset = 1'b1;
        run_access(2, $urandom);

        // random traffic
        for (int it = 0; it < 150; it++) begin
            if (!if_req && !dm_req) begin
                idle_n = $urandom_range(0, 3);
                repeat (idle_n) begin
                    mem_ready = 1'($urandom_range(0, 1));
                    mem_rdata = $urandom;
                    tick();
                    check_quiet("idle");
                end
                mem_ready = 1'b0;
                sel = $urandom_range(1, 3);
                if (sel[0]) raise_if();
                if (sel[1]) raise_dm();
            end else begin
                if (!if_req && $urandom_range(0, 1) == 1) raise_if();
                if (!dm_req && $urandom_range(0, 1) == 1) raise_dm();
            end
            if ($urandom_range(0, 5) == 0) k = $urandom_range(TIMEOUT - 1, TIMEOUT + 2);
            else                           k = $urandom_range(0, 6);
            run_access(k, $urandom);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
